// File: rtl/xor_stream_pkg.sv
// Shared types and helpers for the xor_stream_accum block.
// Holds the two-state FSM encoding and the beat-counter width calculation.
package xor_stream_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Counter must hold the value MAX_BEATS itself, hence the +1.
  function automatic int count_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/xor_stream_accum_xor_reduce.sv
// Combinational WIDTH-bit XOR reduction; yields the single parity bit of a word.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_word,
  output logic             out_bit
);

  // A linear fold; synthesis rebalances it into a log-depth tree.
  always_comb begin
    out_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      out_bit = out_bit ^ in_word[i];
    end
  end

endmodule

// File: rtl/xor_stream_accum.sv
// Per-frame column-wise XOR accumulator with registered valid/ready result.
// Optional beat counter / overflow flag built only when XOR_STREAM_STATS_EN is defined.
module xor_stream_accum
  import xor_stream_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CW        = count_width(MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_parity,
  output logic             out_bit,
  output logic [CW-1:0]    out_beats,
  output logic             out_ovf
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. in_ready and out_valid
  // come straight from flops, so neither side sees a combinational path.

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_parity_q, out_parity_d;
  logic             out_bit_q, out_bit_d;

  logic             beat_fire;
  logic [WIDTH-1:0] acc_next;
  logic             acc_next_bit;

  assign beat_fire = in_valid && in_ready_q;
  assign acc_next  = acc_q ^ in_data;

  xor_reduce #(
    .WIDTH (WIDTH)
  ) u_xor_reduce (
    .in_word (acc_next),
    .out_bit (acc_next_bit)
  );

`ifdef XOR_STREAM_STATS_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] out_beats_q, out_beats_d;
  logic          out_ovf_q, out_ovf_d;
  logic [CW-1:0] cnt_next;
  logic          ovf_next;

  // Count sticks at MAX_BEATS; the overflow flag latches on the first beat past it.
  assign cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign ovf_next = ovf_q | (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    if (state_q == ACCUM && beat_fire) begin
      if (in_last) begin
        out_beats_d = cnt_next;
        out_ovf_d   = ovf_next;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        cnt_d = cnt_next;
        ovf_d = ovf_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;
`else
  assign out_beats = '0;
  assign out_ovf   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    acc_d        = acc_q;
    out_parity_d = out_parity_q;
    out_bit_d    = out_bit_q;
    case (state_q)
      ACCUM: begin
        // in_ready is held low through reset and rises on the first ACCUM cycle.
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (beat_fire) begin
          if (in_last) begin
            out_parity_d = acc_next;
            out_bit_d    = acc_next_bit;
            acc_d        = '0;
            state_d      = HOLD;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
          end else begin
            acc_d = acc_next;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ACCUM;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      acc_q        <= '0;
      out_parity_q <= '0;
      out_bit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      acc_q        <= acc_d;
      out_parity_q <= out_parity_d;
      out_bit_q    <= out_bit_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_bit    = out_bit_q;

endmodule

// File: tb/tb_xor_stream_accum.sv
// Scoreboard bench for xor_stream_accum: directed frames plus random frames,
// expected results computed from whole-frame beat lists.
module tb_xor_stream_accum;
  import xor_stream_pkg::*;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int CW        = $clog2(MAX_BEATS + 1);
  localparam int RW        = WIDTH + 1 + CW + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_parity;
  logic             out_bit;
  logic [CW-1:0]    out_beats;
  logic             out_ovf;

  xor_stream_accum #(
    .WIDTH     (WIDTH),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_bit    (out_bit),
    .out_beats  (out_beats),
    .out_ovf    (out_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [RW-1:0]    exp_q[$];
  logic [WIDTH-1:0] cur_frame[$];

  // 0 = always ready, 1 = stalled, 2 = random
  int  ready_mode = 0;
  bit  holding = 0;
  bit  drop_pending = 0;
  logic [RW-1:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result of a whole frame from its list of beats.
  function automatic logic [RW-1:0] frame_result();
    logic [WIDTH-1:0] p;
    logic             b;
    logic [CW-1:0]    beats;
    logic             ovf;
    int               n;
    p = '0;
    foreach (cur_frame[i]) p = p ^ cur_frame[i];
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) b = b ^ p[i];
    n = cur_frame.size();
`ifdef XOR_STREAM_STATS_EN
    beats = CW'((n > MAX_BEATS) ? MAX_BEATS : n);
    ovf   = (n > MAX_BEATS);
`else
    beats = '0;
    ovf   = 1'b0;
    if (n < 0) beats = '1;
`endif
    return {p, b, beats, ovf};
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (drop_pending) begin
        check("valid_one_cycle", {31'b0, out_valid}, 32'd0);
        drop_pending = 0;
      end else if (out_valid) begin
        check("in_ready_in_hold", {31'b0, in_ready}, 32'd0);
        if (holding) begin
          check("hold_stable", 32'({out_parity, out_bit, out_beats, out_ovf}), 32'(held));
        end else if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(exp_q.size()), 32'd1);
        end else begin
          held = exp_q.pop_front();
          check("out_parity", 32'(out_parity), 32'(held[RW-1 -: WIDTH]));
          check("out_bit",    {31'b0, out_bit}, {31'b0, held[CW+1]});
          check("out_beats",  32'(out_beats),   32'(held[CW:1]));
          check("out_ovf",    {31'b0, out_ovf}, {31'b0, held[0]});
          held = {out_parity, out_bit, out_beats, out_ovf};
          holding = 1;
        end
        if (out_ready) begin
          drop_pending = 1;
          holding = 0;
        end
      end
    end
  end

  // driver
  task automatic send_beat(input logic [WIDTH-1:0] d, input bit last);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cur_frame.push_back(d);
    if (last) begin
      exp_q.push_back(frame_result());
      cur_frame.delete();
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || holding) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    check("rst_out_valid",  {31'b0, out_valid}, 32'd0);
    check("rst_out_parity", 32'(out_parity),    32'd0);
    check("rst_out_bit",    {31'b0, out_bit},   32'd0);
    check("rst_out_beats",  32'(out_beats),     32'd0);
    check("rst_out_ovf",    {31'b0, out_ovf},   32'd0);
    check("rst_in_ready",   {31'b0, in_ready},  {31'b0, exp_ready});
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    cur_frame.delete();
    holding = 0;
    drop_pending = 0;
    repeat (cycles) @(negedge clk);
    check_reset_outputs(1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] d;
    pulse_reset(3);

    send_beat(8'hA5, 1'b1);
    drain();

    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b0);
    send_beat(8'hFE, 1'b1);
    drain();

    // backpressure: second frame waits while the first result is held
    ready_mode = 1;
    send_beat(8'h3C, 1'b1);
    fork
      send_beat(8'hFF, 1'b1);
      begin
        repeat (6) @(posedge clk);
        ready_mode = 0;
      end
    join
    drain();

    // saturation and overflow, then a clean frame
    for (int i = 0; i < 6; i++) send_beat(8'h01, i == 5);
    send_beat(8'h80, 1'b1);
    drain();

    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    pulse_reset(1);
    send_beat(8'h3C, 1'b1);
    drain();

    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b1);
    drain();

    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        d = WIDTH'($urandom_range(0, 255));
        send_beat(d, i == n - 1);
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end
    ready_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
